scoreboard_register_bank: RTL and testbench

Parametrised successor to the single-write, two-read register bank: a register file with a configurable number of combinational read ports, optional write-to-read bypass, and a per-register pending-write scoreboard. It sits in the decode stage of the pipelined MIPS core. Decode marks a destination busy at issue, and writeback clears it. The per-port busy flags drive the hazard/stall logic directly.

---
 rtl/scoreboard_register_bank_pkg.sv | 29 ++
 rtl/scoreboard_register_bank_if.sv | 32 +++
 rtl/scoreboard_register_bank_pending_counter.sv | 46 ++++
 rtl/scoreboard_register_bank.sv | 100 ++++++++++
 tb/tb_scoreboard_register_bank.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/scoreboard_register_bank_pkg.sv
// Shared widths and counter-action decode for the decode-stage register bank.
// Widths here are the project defaults for the bank's parameters.
package scoreboard_register_bank_pkg;

    localparam int DATA_SIZE                  = 32;
    localparam int INSTRUCTION_REGISTER_WIDTH = 5;
    localparam int PENDING_CNT_WIDTH          = 2;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC,
        CNT_UNDERFLOW
    } cnt_op_e;

    // An issue and a writeback landing together cancel out; a lone writeback on an empty counter is an error.
    function automatic cnt_op_e decode_cnt_op(input logic inc, input logic dec,
                                              input logic is_zero, input logic is_full);
        cnt_op_e op;
        op = CNT_HOLD;
        if (inc && !dec) begin
            op = is_full ? CNT_HOLD : CNT_INC;
        end else if (dec && !inc) begin
            op = is_zero ? CNT_UNDERFLOW : CNT_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/scoreboard_register_bank_if.sv
// Read/write/issue bundle between the decode stage and the register bank.
// The bank side is the slave; decode/writeback drive the master side.
interface scoreboard_register_bank_if
    import scoreboard_register_bank_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_SIZE,
    parameter int ADDR_WIDTH     = INSTRUCTION_REGISTER_WIDTH,
    parameter int NUM_READ_PORTS = 2
);

    logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data;
    logic [NUM_READ_PORTS-1:0]            rd_busy;
    logic                                 wr_en;
    logic [ADDR_WIDTH-1:0]                wr_addr;
    logic [DATA_WIDTH-1:0]                wr_data;
    logic                                 issue_en;
    logic [ADDR_WIDTH-1:0]                issue_addr;
    logic                                 issue_ready;
    logic                                 wb_underflow;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        input  rd_data, rd_busy, issue_ready, wb_underflow
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        output rd_data, rd_busy, issue_ready, wb_underflow
    );

endinterface

// File: rtl/scoreboard_register_bank_pending_counter.sv
// Saturating up/down count of outstanding writes to one register.
// Count updates one edge after inc/dec; full and underflow_pulse are immediate.
module pending_counter
    import scoreboard_register_bank_pkg::*;
#(
    parameter int CNT_WIDTH = PENDING_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 full,
    output logic                 underflow_pulse
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    cnt_op_e              op;

    always_comb begin
        op      = decode_cnt_op(inc, dec, count_q == '0, count_q == CNT_MAX);
        count_d = count_q;
        case (op)
            CNT_INC:       count_d = count_q + CNT_WIDTH'(1);
            CNT_DEC:       count_d = count_q - CNT_WIDTH'(1);
            CNT_HOLD:      count_d = count_q;
            CNT_UNDERFLOW: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count           = count_q;
    assign full            = (count_q == CNT_MAX);
    assign underflow_pulse = (op == CNT_UNDERFLOW);

endmodule

// File: rtl/scoreboard_register_bank.sv
// Register file with N combinational read ports, optional write forwarding and a pending-write scoreboard.
// Reads are zero-latency; issues are refused (issue_ready low) once a register's counter is full.
module scoreboard_register_bank
    import scoreboard_register_bank_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_SIZE,
    parameter int ADDR_WIDTH     = INSTRUCTION_REGISTER_WIDTH,
    parameter int NUM_READ_PORTS = 2,
    parameter int BYPASS         = 1,
    parameter int CNT_WIDTH      = PENDING_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    scoreboard_register_bank_if.slave   bus
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  wb_underflow_q;
    logic                  wb_underflow_d;

    logic [CNT_WIDTH-1:0]  pend_cnt [NUM_REGS];
    logic [NUM_REGS-1:0]   cnt_full;
    logic [NUM_REGS-1:0]   cnt_uflow;
    logic                  issue_acc;

    // Register 0 is never written, so its flop stays at its reset value of zero.
    always_comb begin
        regs_d = regs_q;
        if (bus.wr_en && (bus.wr_addr != '0)) begin
            regs_d[bus.wr_addr] = bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign pend_cnt[0]  = '0;
    assign cnt_full[0]  = 1'b0;
    assign cnt_uflow[0] = 1'b0;

    assign bus.issue_ready = (bus.issue_addr == '0) || !cnt_full[bus.issue_addr];
    assign issue_acc       = bus.issue_en && bus.issue_ready;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        logic inc;
        logic dec;

        assign inc = issue_acc && (bus.issue_addr == ADDR_WIDTH'(r));
        assign dec = bus.wr_en && (bus.wr_addr == ADDR_WIDTH'(r));

        pending_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_pending_counter (
            .clk             (clk),
            .reset           (reset),
            .inc             (inc),
            .dec             (dec),
            .count           (pend_cnt[r]),
            .full            (cnt_full[r]),
            .underflow_pulse (cnt_uflow[r])
        );
    end

    always_comb begin
        wb_underflow_d = wb_underflow_q || (|cnt_uflow);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_underflow_q <= 1'b0;
        end else begin
            wb_underflow_q <= wb_underflow_d;
        end
    end

    assign bus.wb_underflow = wb_underflow_q;

    // A forwarded write that retires the last pending issue makes the register ready this cycle.
    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] a;
        logic                  fwd;

        assign a   = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign fwd = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == a) && (a != '0);

        assign bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = fwd ? bus.wr_data : regs_q[a];
        assign bus.rd_busy[p] = (pend_cnt[a] != '0) && !(fwd && (pend_cnt[a] == CNT_WIDTH'(1)));
    end

endmodule

// File: tb/tb_scoreboard_register_bank.sv
// Drives a bypassing and a non-bypassing bank with identical stimulus and checks both.
module tb_scoreboard_register_bank;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NP = 4;
    localparam int CMAX = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    scoreboard_register_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ_PORTS(NP)) if_b ();
    scoreboard_register_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ_PORTS(NP)) if_n ();

    scoreboard_register_bank #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ_PORTS(NP), .BYPASS(1), .CNT_WIDTH(2)
    ) u_dut_byp (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    scoreboard_register_bank #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ_PORTS(NP), .BYPASS(0), .CNT_WIDTH(2)
    ) u_dut_nb (
        .clk   (clk),
        .reset (reset),
        .bus   (if_n.slave)
    );

    int checks = 0;
    int failures = 0;

    logic        cur_we;
    logic [4:0]  cur_wa;
    logic [31:0] cur_wd;
    logic        cur_ie;
    logic [4:0]  cur_ia;
    logic [4:0]  cur_ra [NP];

    logic [31:0] m_mem [32];
    int          m_cnt [32];
    bit          m_uf;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra;
        logic [31:0] d_byp;
        logic [31:0] d_nb;
        logic        busy_byp;
        logic        busy_nb;
        logic        ready;
        logic        uf;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ie, input logic [4:0] ia, input logic [4:0] ra,
                                input logic [31:0] db, input logic [31:0] dn,
                                input logic bb, input logic bn, input logic rdy, input logic uf);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia; v.ra = ra;
        v.d_byp = db; v.d_nb = dn; v.busy_byp = bb; v.busy_nb = bn; v.ready = rdy; v.uf = uf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] r3);
        cur_we = we; cur_wa = wa; cur_wd = wd; cur_ie = ie; cur_ia = ia;
        cur_ra[0] = r0; cur_ra[1] = r1; cur_ra[2] = r2; cur_ra[3] = r3;
        if_b.wr_en = we;  if_b.wr_addr = wa;  if_b.wr_data = wd;
        if_b.issue_en = ie; if_b.issue_addr = ia;
        if_b.rd_addr = {r3, r2, r1, r0};
        if_n.wr_en = we;  if_n.wr_addr = wa;  if_n.wr_data = wd;
        if_n.issue_en = ie; if_n.issue_addr = ia;
        if_n.rd_addr = {r3, r2, r1, r0};
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            m_mem[r] = '0;
            m_cnt[r] = 0;
        end
        m_uf = 1'b0;
    endtask

    // Applies the current cycle's inputs to the reference state, as the clock edge will.
    task automatic model_step();
        bit acc;
        bit wb;
        acc = cur_ie && (cur_ia != 0) && (m_cnt[cur_ia] < CMAX);
        wb  = cur_we && (cur_wa != 0);
        if (wb) m_mem[cur_wa] = cur_wd;
        if (!(acc && wb && cur_ia == cur_wa)) begin
            if (acc) m_cnt[cur_ia] = m_cnt[cur_ia] + 1;
            if (wb) begin
                if (m_cnt[cur_wa] > 0) m_cnt[cur_wa] = m_cnt[cur_wa] - 1;
                else m_uf = 1'b1;
            end
        end
    endtask

    task automatic model_check(input string tag);
        for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < NP; p++) begin
                logic [4:0]  a;
                bit          fwd;
                logic [31:0] exp_d;
                logic        exp_busy;
                logic [31:0] act_d;
                logic        act_busy;
                a        = cur_ra[p];
                fwd      = (b == 1) && cur_we && (cur_wa == a) && (a != 0);
                exp_d    = fwd ? cur_wd : m_mem[a];
                exp_busy = (a != 0) && (m_cnt[a] != 0) && !(fwd && m_cnt[a] == 1);
                act_d    = (b == 1) ? if_b.rd_data[p*DW +: DW] : if_n.rd_data[p*DW +: DW];
                act_busy = (b == 1) ? if_b.rd_busy[p] : if_n.rd_busy[p];
                chk($sformatf("%s_byp%0d_p%0d_data", tag, b, p), act_d, exp_d);
                chk($sformatf("%s_byp%0d_p%0d_busy", tag, b, p), {31'b0, act_busy}, {31'b0, exp_busy});
            end
        end
        chk({tag, "_ready_byp"}, {31'b0, if_b.issue_ready}, {31'b0, (cur_ia == 0) || (m_cnt[cur_ia] < CMAX)});
        chk({tag, "_ready_nb"},  {31'b0, if_n.issue_ready}, {31'b0, (cur_ia == 0) || (m_cnt[cur_ia] < CMAX)});
        chk({tag, "_uf_byp"}, {31'b0, if_b.wb_underflow}, {31'b0, m_uf});
        chk({tag, "_uf_nb"},  {31'b0, if_n.wb_underflow}, {31'b0, m_uf});
    endtask

    task automatic next_cycle();
        if (!reset) model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_clear();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Every register reads back as zero and idle after reset.
        for (int g = 0; g < 8; g++) begin
            drive(0, 0, 0, 0, 5'(g * 4), 5'(g * 4), 5'(g * 4 + 1), 5'(g * 4 + 2), 5'(g * 4 + 3));
            #1;
            model_check($sformatf("reset_g%0d", g));
            next_cycle();
        end

        vecs[0]  = mk(0, 0,  32'h0,        1, 5,  5,  32'h0,        32'h0,        0, 0, 1, 0);
        vecs[1]  = mk(1, 5,  32'hDEADBEEF, 0, 5,  5,  32'hDEADBEEF, 32'h0,        0, 1, 1, 0);
        vecs[2]  = mk(0, 0,  32'h0,        0, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1, 0);
        vecs[3]  = mk(1, 0,  32'h1234,     0, 0,  0,  32'h0,        32'h0,        0, 0, 1, 0);
        vecs[4]  = mk(0, 0,  32'h0,        0, 0,  0,  32'h0,        32'h0,        0, 0, 1, 0);
        vecs[5]  = mk(0, 0,  32'h0,        1, 7,  7,  32'h0,        32'h0,        0, 0, 1, 0);
        vecs[6]  = mk(0, 0,  32'h0,        1, 7,  7,  32'h0,        32'h0,        1, 1, 1, 0);
        vecs[7]  = mk(0, 0,  32'h0,        1, 7,  7,  32'h0,        32'h0,        1, 1, 1, 0);
        vecs[8]  = mk(0, 0,  32'h0,        1, 7,  7,  32'h0,        32'h0,        1, 1, 0, 0);
        vecs[9]  = mk(1, 7,  32'h77,       0, 7,  7,  32'h77,       32'h0,        1, 1, 0, 0);
        vecs[10] = mk(1, 7,  32'h78,       0, 7,  7,  32'h78,       32'h77,       1, 1, 1, 0);
        vecs[11] = mk(1, 7,  32'h79,       0, 7,  7,  32'h79,       32'h78,       0, 1, 1, 0);
        vecs[12] = mk(0, 0,  32'h0,        0, 7,  7,  32'h79,       32'h79,       0, 0, 1, 0);
        vecs[13] = mk(0, 0,  32'h0,        1, 9,  9,  32'h0,        32'h0,        0, 0, 1, 0);
        vecs[14] = mk(1, 9,  32'h99,       1, 9,  9,  32'h99,       32'h0,        0, 1, 1, 0);
        vecs[15] = mk(0, 0,  32'h0,        0, 9,  9,  32'h99,       32'h99,       1, 1, 1, 0);
        vecs[16] = mk(1, 10, 32'hAA,       0, 10, 10, 32'hAA,       32'h0,        0, 0, 1, 0);
        vecs[17] = mk(0, 0,  32'h0,        0, 10, 10, 32'hAA,       32'hAA,       0, 0, 1, 1);
        vecs[18] = mk(0, 0,  32'h0,        0, 10, 10, 32'hAA,       32'hAA,       0, 0, 1, 1);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ie, vecs[i].ia,
                  vecs[i].ra, vecs[i].ra, vecs[i].ra, vecs[i].ra);
            #1;
            chk($sformatf("vec%0d_data_byp", i), if_b.rd_data[DW-1:0], vecs[i].d_byp);
            chk($sformatf("vec%0d_data_nb", i),  if_n.rd_data[DW-1:0], vecs[i].d_nb);
            chk($sformatf("vec%0d_busy_byp", i), {31'b0, if_b.rd_busy[0]}, {31'b0, vecs[i].busy_byp});
            chk($sformatf("vec%0d_busy_nb", i),  {31'b0, if_n.rd_busy[0]}, {31'b0, vecs[i].busy_nb});
            chk($sformatf("vec%0d_ready", i),    {31'b0, if_b.issue_ready}, {31'b0, vecs[i].ready});
            chk($sformatf("vec%0d_uf", i),       {31'b0, if_b.wb_underflow}, {31'b0, vecs[i].uf});
            model_check($sformatf("vec%0d", i));
            next_cycle();
        end

        // r3 gets data and a pending write, then reset lands between edges.
        drive(1, 3, 32'h33, 1, 3, 3, 3, 3, 3);
        #1; model_check("ar_wr");  next_cycle();
        drive(0, 0, 0, 1, 3, 3, 3, 3, 3);
        #1; model_check("ar_iss"); next_cycle();
        drive(0, 0, 0, 0, 3, 3, 3, 3, 3);
        #1;
        chk("ar_pre_busy", {31'b0, if_b.rd_busy[0]}, 32'd1);
        chk("ar_pre_data", if_b.rd_data[DW-1:0], 32'h33);
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        chk("ar_busy_byp", {31'b0, if_b.rd_busy[0]}, 32'd0);
        chk("ar_busy_nb",  {31'b0, if_n.rd_busy[0]}, 32'd0);
        chk("ar_data",     if_n.rd_data[DW-1:0], 32'h0);
        chk("ar_uf",       {31'b0, if_b.wb_underflow}, 32'd0);
        model_check("ar_mid");
        drive(1, 3, 32'h55, 1, 3, 3, 3, 3, 3);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 0, 0, 0, 3, 3, 3, 3, 3);
        #1;
        chk("ar_held_data", if_b.rd_data[DW-1:0], 32'h0);
        chk("ar_held_busy", {31'b0, if_b.rd_busy[0]}, 32'd0);
        model_check("ar_post");
        next_cycle();

        for (int i = 0; i < 500; i++) begin
            logic        we;
            logic [4:0]  wa;
            logic        ie;
            logic [4:0]  ia;
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                model_clear();
            end else begin
                reset = 1'b0;
            end
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 15));
            ie = ($urandom_range(0, 2) != 0);
            ia = 5'($urandom_range(0, 15));
            drive(we, wa, $urandom, ie, ia, wa, ia,
                  5'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
            #1;
            model_check("rnd");
            next_cycle();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
